// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_REFILL_DONE,
    S_UC_AR,
    S_UC_R
  } state_t;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int offset_bits(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int tag_bits(input int index_w, input int line_words);
    return 32 - index_w - offset_bits(line_words);
  endfunction

endpackage

// File: rtl/icache_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle read latency).
module icache_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped I-cache with AXI4 burst refill: hit ok 1 cycle after ren, miss ok 1 cycle after rlast.
// One request in flight, flushed requests still drain AXI; ICACHE_STATS_EN enables hit/miss counters.
module icache_direct
  import cache_pkg::*;
#(
  parameter int INDEX_W    = 7,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic [31:0] addr,
  input  logic        ena,
  input  logic        flush,
  output logic        ok,
  output logic [31:0] rdata,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] axi_rdata,
  input  logic        rvalid,
  input  logic        rlast,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WORD_W = word_bits(LINE_WORDS);
  localparam int OFF_W  = offset_bits(LINE_WORDS);
  localparam int TAG_W  = tag_bits(INDEX_W, LINE_WORDS);
  localparam int LINES  = 2**INDEX_W;

  typedef struct packed {
    logic [31:0] addr;
    logic        ena;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, pend_q, start_req;
  logic              pend_vld_q, dead_q, start;
  logic [WORD_W-1:0] beat_q;
  logic [31:0]       cap_q;
  logic [LINES-1:0]  valid_q;

  logic [INDEX_W-1:0] req_idx, start_idx;
  logic [WORD_W-1:0]  req_word, start_word;
  logic [TAG_W-1:0]   req_tag, tag_rd;
  logic [31:0]        data_rd;
  logic               hit, beat_acc;

  logic unused_rresp;
  assign unused_rresp = ^rresp;

  // A fresh ren beats a queued one: the newest request is the one upstream still wants.
  always_comb begin
    start_req = pend_q;
    if (ren) begin
      start_req.addr = addr;
      start_req.ena  = ena;
    end
    start = (state_q == S_IDLE) && (ren || pend_vld_q);
  end

  assign start_idx  = start_req.addr[OFF_W +: INDEX_W];
  assign start_word = start_req.addr[2 +: WORD_W];
  assign req_idx    = req_q.addr[OFF_W +: INDEX_W];
  assign req_word   = req_q.addr[2 +: WORD_W];
  assign req_tag    = req_q.addr[31 -: TAG_W];

  assign hit      = valid_q[req_idx] && (tag_rd == req_tag);
  assign beat_acc = (state_q == S_MISS_R) && rvalid;

  icache_ram #(.AW(INDEX_W), .DW(TAG_W)) u_tag_ram (
    .clk   (clk),
    .we    (beat_acc && rlast),
    .waddr (req_idx),
    .wdata (req_tag),
    .re    (start),
    .raddr (start_idx),
    .rdata (tag_rd)
  );

  icache_ram #(.AW(INDEX_W + WORD_W), .DW(32)) u_data_ram (
    .clk   (clk),
    .we    (beat_acc),
    .waddr ({req_idx, beat_q}),
    .wdata (axi_rdata),
    .re    (start),
    .raddr ({start_idx, start_word}),
    .rdata (data_rd)
  );

  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;

  always_comb begin
    state_d = state_q;
    ok      = 1'b0;
    rdata   = 32'd0;
    arvalid = 1'b0;
    araddr  = 32'd0;
    arlen   = 8'd0;
    rready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = start_req.ena ? S_LOOKUP : S_UC_AR;
      end
      S_LOOKUP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (hit) begin
          ok      = 1'b1;
          rdata   = data_rd;
          state_d = S_IDLE;
        end else begin
          state_d = S_MISS_AR;
        end
      end
      S_MISS_AR: begin
        arvalid = 1'b1;
        araddr  = {req_q.addr[31:OFF_W], {OFF_W{1'b0}}};
        arlen   = 8'(LINE_WORDS - 1);
        if (arready) state_d = S_MISS_R;
      end
      S_MISS_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_d = S_REFILL_DONE;
      end
      S_REFILL_DONE: begin
        ok      = !dead_q && !flush;
        rdata   = ok ? cap_q : 32'd0;
        state_d = S_IDLE;
      end
      S_UC_AR: begin
        arvalid = 1'b1;
        araddr  = req_q.addr;
        if (arready) state_d = S_UC_R;
      end
      S_UC_R: begin
        rready = 1'b1;
        if (rvalid) begin
          ok      = !dead_q && !flush;
          rdata   = ok ? axi_rdata : 32'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      dead_q     <= 1'b0;
      beat_q     <= '0;
      cap_q      <= 32'd0;
      valid_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        req_q  <= start_req;
        dead_q <= 1'b0;
      end else if (flush && state_q != S_IDLE && state_q != S_LOOKUP) begin
        dead_q <= 1'b1;
      end
      if (ren && state_q != S_IDLE) begin
        pend_q.addr <= addr;
        pend_q.ena  <= ena;
        pend_vld_q  <= 1'b1;
      end else if (flush || start) begin
        pend_vld_q <= 1'b0;
      end
      if (state_q == S_MISS_AR) beat_q <= '0;
      else if (beat_acc)        beat_q <= beat_q + 1'b1;
      if (beat_acc && beat_q == req_word) cap_q <= axi_rdata;
      // A dead refill still validates the line: the data is good, only the requester left.
      if (beat_acc && rlast) valid_q[req_idx] <= 1'b1;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q  <= 32'd0;
      miss_q <= 32'd0;
    end else if (state_q == S_LOOKUP && !flush) begin
      if (hit) hit_q  <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: random-latency AXI slave over a fixed memory image, array-based cache model.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        ena = 1'b0;
  logic        flush = 1'b0;
  logic        ok;
  logic [31:0] rdata;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] axi_rdata = 32'd0;
  logic        rvalid = 1'b0;
  logic        rlast = 1'b0;
  logic [1:0]  rresp = 2'b00;
  logic        rready;
  logic [31:0] hit_cnt, miss_cnt;

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  icache_direct dut (
    .clk(clk), .rst(rst), .ren(ren), .addr(addr), .ena(ena), .flush(flush),
    .ok(ok), .rdata(rdata), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .axi_rdata(axi_rdata),
    .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rready(rready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) * 32'h9E37_79B1 + 32'h0135_7BDF;
  endfunction

  // Memory-side AXI slave with random arready / rvalid gaps.
  int          ar_count = 0;
  int          rlast_cyc = -1;
  logic [31:0] last_araddr = 32'd0;
  logic [7:0]  last_arlen = 8'd0;
  logic [2:0]  last_arsize = 3'd0;
  logic [1:0]  last_arburst = 2'd0;
  bit          uc_override_en = 1'b0;
  logic [31:0] uc_override = 32'd0;
  bit          s_busy = 1'b0;
  logic [31:0] s_addr = 32'd0;
  int          s_len = 0;
  int          s_beat = 0;
  bit          ar_fire, r_fire, rst_s;

  always begin
    @(negedge clk);
    rst_s   = rst;
    ar_fire = rst && arvalid && arready;
    r_fire  = rst && rvalid && rready;
    if (ar_fire) begin
      ar_count++;
      last_araddr  = araddr;
      last_arlen   = arlen;
      last_arsize  = arsize;
      last_arburst = arburst;
    end
    if (r_fire && rlast) rlast_cyc = cyc;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      s_busy = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; axi_rdata = 32'd0;
    end else begin
      if (r_fire) begin
        s_beat++;
        if (s_beat > s_len) s_busy = 1'b0;
      end
      if (ar_fire) begin
        s_busy = 1'b1; s_addr = last_araddr; s_len = int'(last_arlen); s_beat = 0;
      end
      arready = !s_busy && ($urandom_range(0, 1) == 1);
      if (s_busy) begin
        if (!(rvalid && !r_fire)) begin
          rvalid    = ($urandom_range(0, 3) != 0);
          axi_rdata = (uc_override_en && s_len == 0) ? uc_override : mem_word(s_addr + 32'(s_beat * 4));
          rlast     = (s_beat == s_len);
        end
      end else begin
        rvalid = 1'b0; rlast = 1'b0; axi_rdata = 32'd0;
      end
    end
  end

  // Protocol watchers: ok pulse count, rdata idle value, AR stability while waiting.
  int          ok_total = 0;
  int          bad_rdata = 0;
  int          bad_ar = 0;
  logic        prev_arv = 1'b0;
  logic [31:0] prev_araddr = 32'd0;
  logic [7:0]  prev_arlen = 8'd0;

  always @(negedge clk) begin
    if (rst) begin
      if (ok) ok_total++;
      if (!ok && rdata !== 32'd0) bad_rdata++;
      if (prev_arv && arvalid && (araddr !== prev_araddr || arlen !== prev_arlen)) bad_ar++;
    end
    prev_arv    = rst && arvalid;
    prev_araddr = araddr;
    prev_arlen  = arlen;
  end

  // Cache model: line = 32 bytes, 128 lines, tag = address / 4096.
  bit          m_valid [128];
  int unsigned m_tag   [128];
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic m_lookup(input logic [31:0] a, input logic e, output bit exp_hit);
    int unsigned idx, tg;
    idx = (a / 32) % 128;
    tg  = a / 4096;
    exp_hit = 1'b0;
    if (e) begin
      exp_hit = m_valid[idx] && (m_tag[idx] == tg);
      if (exp_hit) m_hits++;
      else begin
        m_misses++;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic e, output bit got,
                       output logic [31:0] d, output int lat, output int okc);
    got = 1'b0; d = 32'd0; lat = 0; okc = -1;
    addr = a; ena = e; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      lat++;
      @(negedge clk);
      if (ok) begin got = 1'b1; d = rdata; okc = cyc; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_rready(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rready) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; addr = $urandom; ena = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b want 0", ok); end
    n_vec++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_vec++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
    n_vec++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b want 0", rready); end
    n_vec++; if (araddr !== 32'd0) begin n_fail++; $display("FAIL reset_araddr: got %h want 0", araddr); end
    n_vec++; if (arlen !== 8'd0) begin n_fail++; $display("FAIL reset_arlen: got %h want 0", arlen); end
    n_vec++; if (arsize !== 3'b010) begin n_fail++; $display("FAIL reset_arsize: got %b want 010", arsize); end
    n_vec++; if (arburst !== 2'b01) begin n_fail++; $display("FAIL reset_arburst: got %b want 01", arburst); end
    n_vec++; if (hit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
    n_vec++; if (miss_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
    @(posedge clk); #1;
    rst = 1'b1; addr = 32'd0; ena = 1'b0;
    m_reset();
  endtask

  task automatic test_cold_miss();
    bit got, eh; logic [31:0] d; int lat, okc, ar0;
    m_lookup(32'h1FC0_0004, 1'b1, eh);
    ar0 = ar_count;
    fetch(32'h1FC0_0004, 1'b1, got, d, lat, okc);
    n_vec++; if (got !== 1'b1) begin n_fail++; $display("FAIL cold_ok: got %b want 1 (timeout)", got); end
    n_vec++; if (d !== mem_word(32'h1FC0_0004)) begin n_fail++; $display("FAIL cold_data: got %h want %h", d, mem_word(32'h1FC0_0004)); end
    n_vec++; if (ar_count - ar0 != 1) begin n_fail++; $display("FAIL cold_ar_count: got %0d want 1", ar_count - ar0); end
    n_vec++; if (last_araddr !== 32'h1FC0_0000) begin n_fail++; $display("FAIL cold_araddr: got %h want 1fc00000", last_araddr); end
    n_vec++; if (last_arlen !== 8'd7) begin n_fail++; $display("FAIL cold_arlen: got %0d want 7", last_arlen); end
    n_vec++; if (last_arsize !== 3'b010 || last_arburst !== 2'b01) begin n_fail++; $display("FAIL cold_size_burst: got %b/%b want 010/01", last_arsize, last_arburst); end
    n_vec++; if (okc != rlast_cyc + 1) begin n_fail++; $display("FAIL cold_ok_timing: ok cycle %0d want %0d", okc, rlast_cyc + 1); end
  endtask

  task automatic test_hit();
    bit got, eh; logic [31:0] d; int lat, okc, ar0;
    m_lookup(32'h1FC0_0008, 1'b1, eh);
    ar0 = ar_count;
    fetch(32'h1FC0_0008, 1'b1, got, d, lat, okc);
    n_vec++; if (d !== mem_word(32'h1FC0_0008) || !got) begin n_fail++; $display("FAIL hit_data: got %h ok=%b want %h", d, got, mem_word(32'h1FC0_0008)); end
    n_vec++; if (lat != 1) begin n_fail++; $display("FAIL hit_latency: got %0d want 1", lat); end
    n_vec++; if (ar_count - ar0 != 0) begin n_fail++; $display("FAIL hit_no_ar: got %0d reads want 0", ar_count - ar0); end
    n_vec++; if (hit_cnt !== (STATS ? 32'(m_hits) : 32'd0)) begin n_fail++; $display("FAIL hit_cnt: got %0d want %0d", hit_cnt, STATS ? m_hits : 0); end
  endtask

  task automatic test_uncached();
    bit got; logic [31:0] d; int lat, okc, ar0;
    uc_override_en = 1'b1; uc_override = 32'hDEAD_BEEF;
    ar0 = ar_count;
    fetch(32'h1FAF_0000, 1'b0, got, d, lat, okc);
    n_vec++; if (d !== 32'hDEAD_BEEF || !got) begin n_fail++; $display("FAIL uc_data: got %h ok=%b want deadbeef", d, got); end
    n_vec++; if (last_araddr !== 32'h1FAF_0000 || last_arlen !== 8'd0) begin n_fail++; $display("FAIL uc_ar: got %h/%0d want 1faf0000/0", last_araddr, last_arlen); end
    n_vec++; if (okc != rlast_cyc) begin n_fail++; $display("FAIL uc_ok_timing: ok cycle %0d want %0d", okc, rlast_cyc); end
    ar0 = ar_count;
    fetch(32'h1FAF_0000, 1'b0, got, d, lat, okc);
    n_vec++; if (ar_count - ar0 != 1 || !got) begin n_fail++; $display("FAIL uc_refetch_ar: got %0d reads ok=%b want 1", ar_count - ar0, got); end
    uc_override_en = 1'b0;
  endtask

  task automatic test_flush();
    bit seen, got, eh; logic [31:0] d; int ar0, ok0, lat, okc, oks;
    m_lookup(32'h1FC0_0040, 1'b1, eh);
    m_lookup(32'h1FC0_0100, 1'b1, eh);
    ar0 = ar_count; ok0 = ok_total;
    addr = 32'h1FC0_0040; ena = 1'b1; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    wait_rready(seen);
    n_vec++; if (!seen) begin n_fail++; $display("FAIL flush_reach_miss_r: rready never seen"); end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; addr = 32'h1FC0_0100; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    got = 1'b0; d = 32'd0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ok) begin got = 1'b1; d = rdata; end
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    oks = ok_total - ok0;
    n_vec++; if (oks != 1) begin n_fail++; $display("FAIL flush_ok_count: got %0d want 1", oks); end
    n_vec++; if (d !== mem_word(32'h1FC0_0100)) begin n_fail++; $display("FAIL flush_new_data: got %h want %h", d, mem_word(32'h1FC0_0100)); end
    n_vec++; if (ar_count - ar0 != 2 || last_araddr !== 32'h1FC0_0100) begin n_fail++; $display("FAIL flush_ar: got %0d reads last %h want 2 last 1fc00100", ar_count - ar0, last_araddr); end
    m_lookup(32'h1FC0_0044, 1'b1, eh);
    ar0 = ar_count;
    fetch(32'h1FC0_0044, 1'b1, got, d, lat, okc);
    n_vec++; if (eh && (lat != 1 || ar_count != ar0)) begin n_fail++; $display("FAIL flush_line_valid: latency %0d reads %0d want 1/0", lat, ar_count - ar0); end
    n_vec++; if (d !== mem_word(32'h1FC0_0044)) begin n_fail++; $display("FAIL flush_line_data: got %h want %h", d, mem_word(32'h1FC0_0044)); end
  endtask

  task automatic test_reset_mid_burst();
    bit seen, got, eh; logic [31:0] d; int lat, okc, ar0;
    m_lookup(32'h1FC0_0060, 1'b1, eh);
    addr = 32'h1FC0_0060; ena = 1'b1; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    wait_rready(seen);
    n_vec++; if (!seen) begin n_fail++; $display("FAIL rstmid_reach_miss_r: rready never seen"); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if ({ok, arvalid, rready} !== 3'b000) begin n_fail++; $display("FAIL rstmid_ctrl: got ok/arvalid/rready=%b want 000", {ok, arvalid, rready}); end
    n_vec++; if (rdata !== 32'd0 || araddr !== 32'd0 || arlen !== 8'd0) begin n_fail++; $display("FAIL rstmid_bus: got %h %h %h want 0", rdata, araddr, arlen); end
    n_vec++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d %0d want 0 0", hit_cnt, miss_cnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    m_reset();
    m_lookup(32'h1FC0_0060, 1'b1, eh);
    ar0 = ar_count;
    fetch(32'h1FC0_0060, 1'b1, got, d, lat, okc);
    n_vec++; if (ar_count - ar0 != (eh ? 0 : 1)) begin n_fail++; $display("FAIL rstmid_refetch_miss: got %0d reads want %0d", ar_count - ar0, eh ? 0 : 1); end
    n_vec++; if (d !== mem_word(32'h1FC0_0060) || !got) begin n_fail++; $display("FAIL rstmid_refetch_data: got %h want %h", d, mem_word(32'h1FC0_0060)); end
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3];
    bit got, eh; logic [31:0] d; int lat, okc, ar0, misses;
    seq[0] = 32'h1FC0_0000; seq[1] = 32'h1FC0_1000; seq[2] = 32'h1FC0_0000;
    misses = 0;
    for (int i = 0; i < 3; i++) begin
      m_lookup(seq[i], 1'b1, eh);
      ar0 = ar_count;
      fetch(seq[i], 1'b1, got, d, lat, okc);
      misses += ar_count - ar0;
      n_vec++; if (d !== mem_word(seq[i]) || !got) begin n_fail++; $display("FAIL conflict_data[%0d]: got %h want %h", i, d, mem_word(seq[i])); end
    end
    n_vec++; if (misses != 3) begin n_fail++; $display("FAIL conflict_misses: got %0d want 3", misses); end
  endtask

  task automatic test_random();
    logic [19:0] tags [4];
    bit got, eh; logic [31:0] a, d; logic e; int lat, okc, ar0;
    tags[0] = 20'h1FC00; tags[1] = 20'h1FC01; tags[2] = 20'h00400; tags[3] = 20'hFFFFF;
    for (int n = 0; n < 150; n++) begin
      a = {tags[$urandom_range(0, 3)], 7'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      e = ($urandom_range(0, 4) != 0);
      m_lookup(a, e, eh);
      ar0 = ar_count;
      fetch(a, e, got, d, lat, okc);
      n_vec++; if (!got) begin n_fail++; $display("FAIL rand_ok[%0d]: addr %h ena %b no ok", n, a, e); end
      n_vec++; if (d !== mem_word(a)) begin n_fail++; $display("FAIL rand_data[%0d]: addr %h got %h want %h", n, a, d, mem_word(a)); end
      n_vec++; if (ar_count - ar0 != (eh ? 0 : 1)) begin n_fail++; $display("FAIL rand_ar[%0d]: addr %h got %0d reads want %0d", n, a, ar_count - ar0, eh ? 0 : 1); end
      if (eh) begin
        n_vec++; if (lat != 1) begin n_fail++; $display("FAIL rand_hit_lat[%0d]: got %0d want 1", n, lat); end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_counters();
    n_vec++; if (hit_cnt !== (STATS ? 32'(m_hits) : 32'd0)) begin n_fail++; $display("FAIL final_hit_cnt: got %0d want %0d", hit_cnt, STATS ? m_hits : 0); end
    n_vec++; if (miss_cnt !== (STATS ? 32'(m_misses) : 32'd0)) begin n_fail++; $display("FAIL final_miss_cnt: got %0d want %0d", miss_cnt, STATS ? m_misses : 0); end
  endtask

  task automatic test_bus_rules();
    n_vec++; if (bad_rdata != 0) begin n_fail++; $display("FAIL rdata_idle_zero: got %0d violations want 0", bad_rdata); end
    n_vec++; if (bad_ar != 0) begin n_fail++; $display("FAIL ar_stable: got %0d violations want 0", bad_ar); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_uncached();
    test_flush();
    test_reset_mid_burst();
    test_conflict();
    test_random();
    test_counters();
    test_bus_rules();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache sitting directly downstream of the CPU-side SRAM interface. Accepts single-word fetch requests (ren pulse + physical address + cacheable flag), returns one-cycle ok/rdata pulses, and refills lines over an AXI4 read-address/read-data channel pair. Uncached fetches bypass the arrays with single-beat AXI reads.

## Interface
- INDEX_W, 7: index bits (2^INDEX_W lines)
- LINE_WORDS, 8: 32-bit words per line (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low
- ren  in  1  fetch request pulse, one cycle
- addr  in  32  physical fetch address, stable from ren until ok or flush
- ena  in  1  1 = cacheable, 0 = uncached; sampled with ren
- flush  in  1  upstream abandons outstanding request
- ok  out  1  read-complete pulse, one cycle
- rdata  out  32  fetched word, valid when ok
- araddr  out  32  AXI read address
- arlen  out  8  burst length − 1
- arsize  out  3  fixed 3'b010
- arburst  out  2  fixed 2'b01 (INCR)
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- axi_rdata  in  32  AXI read data
- rvalid  in  1  AXI data valid
- rlast  in  1  AXI last beat
- rresp  in  2  ignored
- rready  out  1  AXI data ready
- hit_cnt  out  32  hit counter (see Configuration)
- miss_cnt  out  32  miss counter (see Configuration)

## Operation
- Address split: [1:0] byte, word = next log2(LINE_WORDS) bits, index = next INDEX_W, tag = remaining upper bits (20 with defaults).
- States: IDLE, LOOKUP, MISS_AR, MISS_R, REFILL_DONE, UC_AR, UC_R.
- IDLE: ren & ena → LOOKUP (array read issued); ren & !ena → UC_AR.
- LOOKUP: valid & tag match → ok=1, rdata = hit word, → IDLE. Else → MISS_AR.
- MISS_AR: arvalid=1, araddr = line-aligned addr, arlen = LINE_WORDS−1; on arready → MISS_R.
- MISS_R: rready=1; each beat writes data array at beat counter; beat matching requested word captured; on rlast beat tag written, valid set → REFILL_DONE.
- REFILL_DONE: ok=1 with captured word → IDLE.
- UC_AR: araddr = addr, arlen=0; on arready → UC_R. UC_R: rready=1; on rvalid → ok=1, rdata = axi_rdata → IDLE. No array write.
- Flush: in LOOKUP → suppress ok, → IDLE. In AR/R/REFILL_DONE → mark request dead; AXI transaction always completes, refill still validates line, ok suppressed.
- Pending slot (one entry): ren while not IDLE (only possible after flush) latches addr/ena; serviced from IDLE next cycle as if fresh. Second ren while slot full overwrites it. flush clears pending slot.
- rdata holds 0 when ok=0.

## Timing
- Reset: ok=0, rdata=0, arvalid=0, rready=0, araddr=0, arlen=0, all valid bits 0, state IDLE, pending empty, counters 0.
- Hit: ok one cycle after ren.
- Miss: arvalid cycle after LOOKUP; ok one cycle after rlast beat accepted.
- Uncached: arvalid cycle after ren; ok same cycle as accepted rvalid.
- arvalid held until arready; address/len stable while arvalid.
- Reset mid-burst: state machine returns to IDLE immediately, AXI beats in flight dropped (interconnect reset together).
- Same-index refill overwrites older tag unconditionally.

## Configuration
- ICACHE_STATS_EN defined: hit_cnt increments on each LOOKUP hit, miss_cnt on each miss entering MISS_AR (flushed requests counted); 32-bit, wrap at 2^32. Undefined: both outputs tied 0, no counter logic.

## Structure
- cache_pkg: state enum, AXI burst/size constants, address-field width functions.
- Sub-module icache_ram: simple dual-port sync-read RAM, write port for refill, read port for lookup; instantiated for tag and data arrays.

## Test plan
- Cold fetch 0x1FC00004 cacheable → AR 0x1FC00000 arlen=7; 8 beats D0..D7 → ok with D1 one cycle after rlast.
- Repeat 0x1FC00008 → ok one cycle after ren, rdata D2, no AR; hit_cnt=1.
- Uncached 0x1FAF0000 → AR arlen=0; beat 0xDEADBEEF → ok same cycle; second fetch misses again.
- Flush during MISS_R, new ren 0x1FC00100 → no ok for first; burst completes; then AR 0x1FC00100, ok for it only.
- 0x1FC00000 then 0x1FC01000 (same index) then 0x1FC00000 → three misses.
- rst low mid-burst → outputs at reset values next cycle; refetch misses.
